// File: rtl/core_mem_if.sv
// Load/store bus master between the execute stage and a valid/ack system bus.
// Every access starts with a read beat; stores add a write beat of the merged word.
module core_mem_if #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_req_in,
    input  logic        ex_rw_in,
    input  logic [31:0] ex_addr_in,
    input  logic [31:0] ex_wdata_in,
    output logic [31:0] ex_rdata_out,
    output logic        hold_flag_out,
    output logic        mem_err_out,
    output logic        bus_req_out,
    output logic        bus_we_out,
    output logic [31:0] bus_addr_out,
    output logic [31:0] bus_wdata_out,
    input  logic        bus_ack_in,
    input  logic [31:0] bus_rdata_in
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                is_wr_q, is_wr_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic                err_q, err_d;

    logic ack;
    logic expired;

    // An ack only counts while a beat is actually on the bus.
    assign ack     = bus_ack_in & req_q;
    assign expired = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        req_d   = req_q;
        we_d    = we_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ex_req_in) begin
                    state_d = RD;
                    addr_d  = ex_addr_in;
                    is_wr_d = ex_rw_in;
                    we_d    = 1'b0;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            RD: begin
                if (ack) begin
                    rdata_d = bus_rdata_in;
                    cnt_d   = '0;
                    if (is_wr_q) begin
                        // Execute stage has already merged its lanes into ex_wdata_in.
                        state_d = WR;
                        we_d    = 1'b1;
                        wdata_d = ex_wdata_in;
                    end else begin
                        state_d = DONE;
                        req_d   = 1'b0;
                    end
                end else if (expired) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR: begin
                if (ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end else if (expired) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    // Hold is released in DONE so the pipeline advances on that edge.
    assign hold_flag_out = !rst && ((state_q == RD) || (state_q == WR) ||
                                    ((state_q == IDLE) && ex_req_in));

    assign ex_rdata_out  = rdata_q;
    assign mem_err_out   = err_q;
    assign bus_req_out   = req_q;
    assign bus_we_out    = we_q;
    assign bus_addr_out  = addr_q;
    assign bus_wdata_out = wdata_q;

endmodule

// File: tb/tb_core_mem_if.sv
// Self-checking bench for core_mem_if: directed vector table, reset corner case,
// and randomized accesses against a transaction-level reference model.
module tb_core_mem_if;

    // Short timeout keeps abort cases quick while still allowing a 5-cycle slow ack.
    localparam int T = 8;

    logic        clk;
    logic        rst;
    logic        ex_req_in;
    logic        ex_rw_in;
    logic [31:0] ex_addr_in;
    logic [31:0] ex_wdata_in;
    logic [31:0] ex_rdata_out;
    logic        hold_flag_out;
    logic        mem_err_out;
    logic        bus_req_out;
    logic        bus_we_out;
    logic [31:0] bus_addr_out;
    logic [31:0] bus_wdata_out;
    logic        bus_ack_in;
    logic [31:0] bus_rdata_in;

    core_mem_if #(
        .TIMEOUT_CYCLES(T),
        .CNT_WIDTH     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_req_in    (ex_req_in),
        .ex_rw_in     (ex_rw_in),
        .ex_addr_in   (ex_addr_in),
        .ex_wdata_in  (ex_wdata_in),
        .ex_rdata_out (ex_rdata_out),
        .hold_flag_out(hold_flag_out),
        .mem_err_out  (mem_err_out),
        .bus_req_out  (bus_req_out),
        .bus_we_out   (bus_we_out),
        .bus_addr_out (bus_addr_out),
        .bus_wdata_out(bus_wdata_out),
        .bus_ack_in   (bus_ack_in),
        .bus_rdata_in (bus_rdata_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] mask;
        logic [31:0] val;
        int          d_rd;
        int          d_wr;
    } txn_t;

    typedef struct {
        bit          done;
        logic [31:0] rdata;
        logic [31:0] wdata;
        int          hold;
        int          err;
        int          reads;
        int          writes;
        int          first_req;
        int          addr_bad;
    } res_t;

    typedef struct {
        txn_t t;
        res_t e;
    } vec_t;

    logic [31:0] bus_mem [256];
    logic [31:0] ref_mem [256];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic txn_t mk_txn(input logic rw, input logic [31:0] addr, input logic [31:0] mask,
                                    input logic [31:0] val, input int d_rd, input int d_wr);
        txn_t t;
        t.rw = rw; t.addr = addr; t.mask = mask; t.val = val; t.d_rd = d_rd; t.d_wr = d_wr;
        return t;
    endfunction

    function automatic res_t mk_exp(input logic [31:0] rdata, input int hold, input int err,
                                    input int reads, input int writes, input logic [31:0] wdata);
        res_t r;
        r = '{default: 0};
        r.done = 1'b1; r.rdata = rdata; r.hold = hold; r.err = err;
        r.reads = reads; r.writes = writes; r.wdata = wdata;
        return r;
    endfunction

    // Transaction-level model: ack delay d means the beat completes on its (d+1)-th cycle,
    // a beat lasting T cycles without ack aborts; hold covers the IDLE request cycle plus all beats.
    function automatic res_t model(input txn_t t);
        res_t        r;
        logic [31:0] old;
        old = ref_mem[t.addr[9:2]];
        r = '{default: 0};
        r.done = 1'b1;
        if (t.d_rd >= T) begin
            r.hold = 1 + T; r.err = 1; r.rdata = 32'h0;
        end else begin
            r.reads = 1; r.rdata = old;
            if (!t.rw) begin
                r.hold = 1 + t.d_rd + 1;
            end else if (t.d_wr >= T) begin
                r.hold = 1 + t.d_rd + 1 + T; r.err = 1;
            end else begin
                r.hold = 1 + t.d_rd + 1 + t.d_wr + 1; r.writes = 1;
                r.wdata = (old & ~t.mask) | (t.val & t.mask);
            end
        end
        return r;
    endfunction

    // Acts as execute stage and bus slave for one access; starts and ends at posedge+1.
    task automatic run_txn(input txn_t t, input bit stray, output res_t o);
        int rd_wait = 0;
        int wr_wait = 0;
        bit done    = 1'b0;
        o = '{default: 0};
        ex_req_in  = 1'b1;
        ex_rw_in   = t.rw;
        ex_addr_in = t.addr;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            bus_ack_in   = 1'b0;
            bus_rdata_in = $urandom;
            if (cyc == 0) o.first_req = int'(bus_req_out);
            if (bus_req_out) begin
                if (bus_addr_out !== t.addr) o.addr_bad++;
                if (!bus_we_out) begin
                    if (rd_wait == t.d_rd) begin
                        bus_ack_in   = 1'b1;
                        bus_rdata_in = bus_mem[t.addr[9:2]];
                        o.reads++;
                    end
                    rd_wait++;
                end else begin
                    if (wr_wait == t.d_wr) begin
                        bus_ack_in = 1'b1;
                        bus_mem[bus_addr_out[9:2]] = bus_wdata_out;
                        o.writes++;
                        o.wdata = bus_wdata_out;
                    end
                    wr_wait++;
                end
            end else if (stray) begin
                bus_ack_in = 1'($urandom_range(0, 1));
            end
            ex_wdata_in = (bus_rdata_in & ~t.mask) | (t.val & t.mask);
            #1;
            if (mem_err_out) o.err++;
            if (hold_flag_out) o.hold++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus_ack_in = 1'b0;
        o.done  = done;
        o.rdata = ex_rdata_out;
    endtask

    task automatic compare(input string tag, input res_t o, input res_t e);
        check($sformatf("%s.done", tag),      32'(o.done),      32'(e.done));
        check($sformatf("%s.hold", tag),      32'(o.hold),      32'(e.hold));
        check($sformatf("%s.err", tag),       32'(o.err),       32'(e.err));
        check($sformatf("%s.reads", tag),     32'(o.reads),     32'(e.reads));
        check($sformatf("%s.writes", tag),    32'(o.writes),    32'(e.writes));
        if (e.writes != 0) check($sformatf("%s.wdata", tag), o.wdata, e.wdata);
        check($sformatf("%s.rdata", tag),     o.rdata,          e.rdata);
        check($sformatf("%s.first_req", tag), 32'(o.first_req), 32'(0));
        check($sformatf("%s.addr_bad", tag),  32'(o.addr_bad),  32'(0));
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] w);
        bus_mem[addr[9:2]] = w;
        ref_mem[addr[9:2]] = w;
    endtask

    vec_t vecs [9];

    initial begin
        res_t        o;
        res_t        e;
        txn_t        t;
        logic [31:0] w;
        int          r;

        rst          = 1'b1;
        ex_req_in    = 1'b1;
        ex_rw_in     = 1'b0;
        ex_addr_in   = 32'h0;
        ex_wdata_in  = 32'h0;
        bus_ack_in   = 1'b0;
        bus_rdata_in = 32'h0;

        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            preload(32'(i) << 2, w);
        end
        preload(32'h100, 32'hDEADBEEF);
        preload(32'h204, 32'h11223344);
        preload(32'h108, 32'hCAFEF00D);
        preload(32'h10C, 32'h0BADF00D);
        preload(32'h210, 32'h55667788);
        preload(32'h000, 32'hA0A0A0A0);
        preload(32'h004, 32'hB1B1B1B1);

        vecs[0] = '{mk_txn(0, 32'h100, 32'h0, 32'h0, 0, 0),                 mk_exp(32'hDEADBEEF, 2, 0, 1, 0, 32'h0)};
        vecs[1] = '{mk_txn(1, 32'h204, 32'h000000FF, 32'h000000AA, 0, 0),   mk_exp(32'h11223344, 3, 0, 1, 1, 32'h112233AA)};
        vecs[2] = '{mk_txn(0, 32'h108, 32'h0, 32'h0, 5, 0),                 mk_exp(32'hCAFEF00D, 7, 0, 1, 0, 32'h0)};
        vecs[3] = '{mk_txn(1, 32'h20C, 32'h000000FF, 32'h00000055, 99, 0),  mk_exp(32'h00000000, 9, 1, 0, 0, 32'h0)};
        vecs[4] = '{mk_txn(0, 32'h10C, 32'h0, 32'h0, 7, 0),                 mk_exp(32'h0BADF00D, 9, 0, 1, 0, 32'h0)};
        vecs[5] = '{mk_txn(1, 32'h210, 32'hFFFF0000, 32'h12345678, 0, 99),  mk_exp(32'h55667788, 10, 1, 1, 0, 32'h0)};
        vecs[6] = '{mk_txn(0, 32'h000, 32'h0, 32'h0, 0, 0),                 mk_exp(32'hA0A0A0A0, 2, 0, 1, 0, 32'h0)};
        vecs[7] = '{mk_txn(0, 32'h004, 32'h0, 32'h0, 0, 0),                 mk_exp(32'hB1B1B1B1, 2, 0, 1, 0, 32'h0)};
        vecs[8] = '{mk_txn(1, 32'h204, 32'h0000FF00, 32'h0000BB00, 2, 3),   mk_exp(32'h112233AA, 8, 0, 1, 1, 32'h1122BBAA)};

        // Reset state, with a request pending to show hold is forced low.
        #3;
        check("rst.hold",      32'(hold_flag_out), 32'(0));
        check("rst.bus_req",   32'(bus_req_out),   32'(0));
        check("rst.bus_we",    32'(bus_we_out),    32'(0));
        check("rst.bus_addr",  bus_addr_out,       32'h0);
        check("rst.bus_wdata", bus_wdata_out,      32'h0);
        check("rst.ex_rdata",  ex_rdata_out,       32'h0);
        check("rst.mem_err",   32'(mem_err_out),   32'(0));
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        ex_req_in = 1'b0;
        @(posedge clk);
        #1;
        check("idle.hold",    32'(hold_flag_out), 32'(0));
        check("idle.bus_req", 32'(bus_req_out),   32'(0));

        // Directed vectors, issued back to back.
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].t, 1'b0, o);
            compare($sformatf("vec%0d", i), o, vecs[i].e);
            if (vecs[i].e.writes != 0) ref_mem[vecs[i].t.addr[9:2]] = vecs[i].e.wdata;
        end

        // Reset asserted during the write beat of a store.
        ex_req_in  = 1'b1;
        ex_rw_in   = 1'b1;
        ex_addr_in = 32'h300;
        @(posedge clk);
        #1;
        check("mid.rd_req",  32'(bus_req_out), 32'(1));
        check("mid.rd_we",   32'(bus_we_out),  32'(0));
        check("mid.rd_addr", bus_addr_out,     32'h300);
        bus_ack_in   = 1'b1;
        bus_rdata_in = 32'h77777777;
        ex_wdata_in  = 32'h777777CC;
        @(posedge clk);
        #1;
        bus_ack_in = 1'b0;
        check("mid.wr_we",    32'(bus_we_out),    32'(1));
        check("mid.wr_wdata", bus_wdata_out,      32'h777777CC);
        check("mid.wr_rdata", ex_rdata_out,       32'h77777777);
        check("mid.wr_hold",  32'(hold_flag_out), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check("mid.rst_req",   32'(bus_req_out),   32'(0));
        check("mid.rst_we",    32'(bus_we_out),    32'(0));
        check("mid.rst_addr",  bus_addr_out,       32'h0);
        check("mid.rst_wdata", bus_wdata_out,      32'h0);
        check("mid.rst_rdata", ex_rdata_out,       32'h0);
        check("mid.rst_hold",  32'(hold_flag_out), 32'(0));
        @(negedge clk);
        rst        = 1'b0;
        ex_req_in  = 1'b0;
        bus_ack_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stray%0d.req", i),  32'(bus_req_out),   32'(0));
            check($sformatf("stray%0d.hold", i), 32'(hold_flag_out), 32'(0));
            check($sformatf("stray%0d.err", i),  32'(mem_err_out),   32'(0));
        end
        bus_ack_in = 1'b0;

        // Randomized accesses over a small address window so stores and loads collide.
        for (int i = 0; i < 60; i++) begin
            t.rw   = 1'($urandom_range(0, 1));
            t.addr = 32'($urandom_range(0, 15)) << 2;
            r = $urandom_range(0, 5);
            case (r)
                0: t.mask = 32'h000000FF;
                1: t.mask = 32'h0000FF00;
                2: t.mask = 32'h00FF0000;
                3: t.mask = 32'hFF000000;
                4: t.mask = 32'h0000FFFF;
                default: t.mask = 32'hFFFFFFFF;
            endcase
            t.val = $urandom;
            r = $urandom_range(0, 9);
            t.d_rd = (r < 6) ? (r % 3) : (r == 6) ? T - 1 : (r == 7) ? 5 : 50;
            r = $urandom_range(0, 9);
            t.d_wr = (r < 6) ? (r % 3) : (r == 6) ? T - 1 : (r == 7) ? 4 : 50;
            if ($urandom_range(0, 3) == 0) begin
                ex_req_in = 1'b0;
                @(posedge clk);
                #1;
                check($sformatf("rnd%0d.gap_hold", i), 32'(hold_flag_out), 32'(0));
            end
            e = model(t);
            run_txn(t, 1'b1, o);
            compare($sformatf("rnd%0d", i), o, e);
            if (e.writes != 0) ref_mem[t.addr[9:2]] = e.wdata;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
